// File: rtl/rr_mux_n_if.sv
// Handshake bundle for rr_mux_n: CH request channels in, one registered stream out.
// The DUT connects through the slave modport and the producer/consumer side through the master modport.
interface rr_mux_n_if #(
   parameter int N  = 4,
   parameter int CH = 4,
   parameter int SW = 2
);
   logic [CH*N-1:0] in_data;
   logic [CH-1:0]   in_valid;
   logic [CH-1:0]   in_ready;
   logic [N-1:0]    out_data;
   logic [SW-1:0]   out_sel;
   logic            out_valid;
   logic            out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_sel, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_sel, out_valid
   );
endinterface

// File: rtl/rr_mux_n.sv
// Round-robin arbitrating mux: CH producers share one registered output stream.
// Define RR_MUX_N_SKID_EN for a 2-entry skid buffer that cuts the out_ready->in_ready path.
module rr_mux_n #(
   parameter int N  = 4,
   parameter int CH = 4,
   parameter int SW = 2
) (
   input logic      clk,
   input logic      rst,
   rr_mux_n_if.slave bus
);

   logic [SW-1:0] ptr;
   logic [SW-1:0] grant;
   logic          found;
   logic          accept;
   logic          push;
   logic          pop;
   logic [N-1:0]  new_data;
   logic [N-1:0]  head_data;
   logic [SW-1:0] head_sel;

   // First requester at or after ptr, wrapping modulo CH (CH need not be a power of two).
   always_comb begin
      int j;
      logic [SW-1:0] idx;
      j     = 0;
      idx   = '0;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < CH; i++) begin
         j = int'(ptr) + i;
         if (j >= CH) j = j - CH;
         idx = SW'(j);
         if (!found && bus.in_valid[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   assign new_data = bus.in_data[int'(grant)*N +: N];
   assign push     = found && accept;
   assign pop      = bus.out_valid && bus.out_ready;

   always_comb begin
      bus.in_ready = '0;
      if (found && accept && !rst) bus.in_ready[grant] = 1'b1;
   end

   // The pointer only advances past a channel once it has actually transferred.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (push)
         ptr <= (grant == SW'(CH - 1)) ? '0 : grant + 1'b1;
   end

`ifdef RR_MUX_N_SKID_EN
   logic [1:0]    count;
   logic [N-1:0]  tail_data;
   logic [SW-1:0] tail_sel;

   assign accept        = (count != 2'd2);
   assign bus.out_valid = (count != 2'd0);

   // Head is what the consumer sees; tail only fills when the head is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= 2'd0;
         head_data <= '0;
         head_sel  <= '0;
         tail_data <= '0;
         tail_sel  <= '0;
      end else begin
         if (pop && count == 2'd2) begin
            head_data <= tail_data;
            head_sel  <= tail_sel;
         end else if (push && (count == 2'd0 || pop)) begin
            head_data <= new_data;
            head_sel  <= grant;
         end else if (push) begin
            tail_data <= new_data;
            tail_sel  <= grant;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
`else
   logic head_valid;

   assign accept        = !head_valid || bus.out_ready;
   assign bus.out_valid = head_valid;

   // Single output register, refilled in the same cycle it drains.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_valid <= 1'b0;
         head_data  <= '0;
         head_sel   <= '0;
      end else if (push) begin
         head_valid <= 1'b1;
         head_data  <= new_data;
         head_sel   <= grant;
      end else if (pop) begin
         head_valid <= 1'b0;
      end
   end
`endif

   assign bus.out_data = head_data;
   assign bus.out_sel  = head_sel;

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed bench for rr_mux_n: a 4-channel instance for most scenarios and a 3-channel one for the
// non-power-of-two rotation. Expectations adapt to RR_MUX_N_SKID_EN when it is defined.
module tb_rr_mux_n;

`ifdef RR_MUX_N_SKID_EN
   localparam int SKID = 1;
`else
   localparam int SKID = 0;
`endif

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   rr_mux_n_if #(.N(4), .CH(4), .SW(2)) b4 ();
   rr_mux_n_if #(.N(4), .CH(3), .SW(2)) b3 ();

   rr_mux_n #(.N(4), .CH(4), .SW(2)) dut4 (.clk(clk), .rst(rst), .bus(b4));
   rr_mux_n #(.N(4), .CH(3), .SW(2)) dut3 (.clk(clk), .rst(rst), .bus(b3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Inputs change just after the edge; outputs are sampled two time units later.
   task automatic applyStimulus(input logic [3:0] v, input logic rdy, input logic [15:0] data);
      b4.in_valid  = v;
      b4.out_ready = rdy;
      b4.in_data   = data;
      #2;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst          = 1'b1;
      b3.in_data   = 12'h321;
      b3.in_valid  = 3'b000;
      b3.out_ready = 1'b1;

      // Reset held for two edges with every channel requesting
      applyStimulus(4'b1111, 1'b1, 16'hDCBA);
      tick;
      tick;
      applyStimulus(4'b1111, 1'b1, 16'hDCBA);
      checkOutput("rst_in_ready", 32'(b4.in_ready), 32'h0);
      checkOutput("rst_out_valid", 32'(b4.out_valid), 32'h0);
      checkOutput("rst_out_data", 32'(b4.out_data), 32'h0);
      checkOutput("rst_out_sel", 32'(b4.out_sel), 32'h0);

      rst = 1'b0;
      applyStimulus(4'b1111, 1'b1, 16'hDCBA);
      checkOutput("first_grant", 32'(b4.in_ready), 32'h1);
      tick;

      // Full rotation, one transfer per cycle
      for (int i = 0; i < 8; i++) begin
         applyStimulus(4'b1111, 1'b1, 16'hDCBA);
         checkOutput("rot_valid", 32'(b4.out_valid), 32'h1);
         checkOutput("rot_sel", 32'(b4.out_sel), 32'(i % 4));
         checkOutput("rot_data", 32'(b4.out_data), 32'(10 + (i % 4)));
         checkOutput("rot_in_ready", 32'(b4.in_ready), 32'(1 << ((i + 1) % 4)));
         tick;
      end

      // Pointer skip and wrap: ptr=1 here, channel 2 pushes, ptr wraps past 3 to 0
      applyStimulus(4'b0100, 1'b1, 16'hDCBA);
      checkOutput("skip_grant2", 32'(b4.in_ready), 32'h4);
      tick;
      applyStimulus(4'b0101, 1'b1, 16'hDCBA);
      checkOutput("wrap_grant0", 32'(b4.in_ready), 32'h1);
      checkOutput("wrap_sel2", 32'(b4.out_sel), 32'h2);
      checkOutput("wrap_data2", 32'(b4.out_data), 32'hC);
      tick;
      applyStimulus(4'b0101, 1'b1, 16'hDCBA);
      checkOutput("next_grant2", 32'(b4.in_ready), 32'h4);
      checkOutput("next_sel0", 32'(b4.out_sel), 32'h0);
      checkOutput("next_data0", 32'(b4.out_data), 32'hA);
      tick;
      applyStimulus(4'b0000, 1'b1, 16'hDCBA);
      checkOutput("last_sel2", 32'(b4.out_sel), 32'h2);
      checkOutput("last_valid", 32'(b4.out_valid), 32'h1);
      tick;
      applyStimulus(4'b0000, 1'b1, 16'hDCBA);
      checkOutput("drained", 32'(b4.out_valid), 32'h0);

      // Back-pressure: channel 1 carries 4'h7, consumer stalled for 5 cycles
      applyStimulus(4'b0010, 1'b0, 16'hDC7A);
      checkOutput("bp_accept", 32'(b4.in_ready), 32'h2);
      tick;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(4'b0010, 1'b0, 16'hDC7A);
         checkOutput("bp_valid", 32'(b4.out_valid), 32'h1);
         checkOutput("bp_data", 32'(b4.out_data), 32'h7);
         checkOutput("bp_sel", 32'(b4.out_sel), 32'h1);
         checkOutput("bp_in_ready", 32'(b4.in_ready), (k < SKID) ? 32'h2 : 32'h0);
         tick;
      end
      applyStimulus(4'b0000, 1'b1, 16'hDC7A);
      checkOutput("bp_rel_valid", 32'(b4.out_valid), 32'h1);
      checkOutput("bp_rel_sel", 32'(b4.out_sel), 32'h1);
      checkOutput("bp_rel_data", 32'(b4.out_data), 32'h7);
      tick;
      applyStimulus(4'b0000, 1'b1, 16'hDC7A);
      checkOutput("bp_second", 32'(b4.out_valid), 32'(SKID));
      tick;
      applyStimulus(4'b0000, 1'b1, 16'hDC7A);
      checkOutput("bp_empty", 32'(b4.out_valid), 32'h0);

      // Mid-operation reset with the buffer full and ptr away from 0
      applyStimulus(4'b0110, 1'b0, 16'hDCBA);
      checkOutput("fill_grant2", 32'(b4.in_ready), 32'h4);
      tick;
      tick;
      applyStimulus(4'b0110, 1'b0, 16'hDCBA);
      checkOutput("full_valid", 32'(b4.out_valid), 32'h1);
      checkOutput("full_sel", 32'(b4.out_sel), 32'h2);
      checkOutput("full_data", 32'(b4.out_data), 32'hC);
      checkOutput("full_in_ready", 32'(b4.in_ready), 32'h0);
      rst = 1'b1;
      applyStimulus(4'b1111, 1'b0, 16'hDCBA);
      checkOutput("mid_rst_in_ready", 32'(b4.in_ready), 32'h0);
      tick;
      rst = 1'b0;
      applyStimulus(4'b1111, 1'b0, 16'hDCBA);
      checkOutput("post_rst_valid", 32'(b4.out_valid), 32'h0);
      checkOutput("post_rst_data", 32'(b4.out_data), 32'h0);
      checkOutput("post_rst_sel", 32'(b4.out_sel), 32'h0);
      checkOutput("post_rst_grant", 32'(b4.in_ready), 32'h1);
      tick;
      applyStimulus(4'b1111, 1'b1, 16'hDCBA);
      checkOutput("post_rst_push_sel", 32'(b4.out_sel), 32'h0);
      checkOutput("post_rst_push_data", 32'(b4.out_data), 32'hA);
      checkOutput("post_rst_push_valid", 32'(b4.out_valid), 32'h1);
      tick;

      // Three-channel instance: select must cycle 0,1,2 and never reach 3
      b3.in_valid = 3'b111;
      applyStimulus(4'b0000, 1'b1, 16'hDCBA);
      checkOutput("ch3_first_grant", 32'(b3.in_ready), 32'h1);
      tick;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(4'b0000, 1'b1, 16'hDCBA);
         checkOutput("ch3_valid", 32'(b3.out_valid), 32'h1);
         checkOutput("ch3_sel", 32'(b3.out_sel), 32'(i % 3));
         checkOutput("ch3_data", 32'(b3.out_data), 32'(1 + (i % 3)));
         tick;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
